// File: rtl/subtractor_32_seq.sv
// Multi-cycle subtractor: a - b - bin, one SLICE-bit slice per clock, LSB slice first.
// Operands sit in shift registers and the result is shifted in from the top, so no slice indexing is needed.
module subtractor_32_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              brw_q, brw_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE:0]    slice_res;
  logic [WIDTH-1:0]  slice_top;

  // Low slice of the remaining operands; bit SLICE of the result is the slice borrow-out.
  always_comb begin
    slice_res = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - (SLICE+1)'(brw_q);
    slice_top = WIDTH'(slice_res[SLICE-1:0]) << (WIDTH - SLICE);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> SLICE;
        b_d    = b_q >> SLICE;
        brw_d  = slice_res[SLICE];
        diff_d = (diff_q >> SLICE) | slice_top;
        idx_d  = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // On the last slice the low bits of a_q/b_q hold the original operand MSBs.
          bout_d  = slice_res[SLICE];
          ovf_d   = (a_q[SLICE-1] != b_q[SLICE-1]) && (slice_res[SLICE-1] != a_q[SLICE-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    brw_q <= brw_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_subtractor_32_seq.sv
// Scoreboard bench for subtractor_32_seq: expected results queued at issue, compared while out_valid is high.
module tb_subtractor_32_seq;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  subtractor_32_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned 33-bit difference for diff/bout, wide signed arithmetic for overflow.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    exp_t        r;
    logic [32:0] t;
    longint      sr;
    t    = {1'b0, ma} - {1'b0, mb} - 33'(mbin);
    r.d  = t[31:0];
    r.bo = t[32];
    sr   = longint'($signed(ma)) - longint'($signed(mb)) - longint'({63'd0, mbin});
    r.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        check_eq("diff", 64'(diff), 64'(sb[0].d));
        check_eq("bout", 64'(bout), 64'(sb[0].bo));
        check_eq("ovf",  64'(ovf),  64'(sb[0].ov));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Caller is at posedge+1; returns at accepting edge+1 with in_valid dropped.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ibin, input bit push);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("in_ready_before_issue", 64'(in_ready), 64'd1);
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    if (push) sb.push_back(model(ia, ib, ibin));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 20);
    check_eq({tag, "_latency"}, 64'(cyc), 64'd4);
    cyc = 0;
    while (out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_ready_after_release"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_valid_after_release"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] va [6] = '{32'h0000_0000, 32'h0000_0005, 32'h0100_0000, 32'h0000_0100, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [31:0] vb [6] = '{32'h0000_0001, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
  logic        vbin[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1; bin = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    check_eq("reset_in_ready",  64'(in_ready),  64'd1);
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_diff",      64'(diff),      64'd0);
    check_eq("reset_bout",      64'(bout),      64'd0);
    check_eq("reset_ovf",       64'(ovf),       64'd0);

    issue(32'd25, 32'd7, 1'b1, 1'b1);
    wait_result("basic");

    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vbin[i], 1'b1);
      wait_result("vector");
    end

    for (int i = 0; i < 8; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(1)), 1'b1);
      wait_result("random");
    end

    // Backpressure with junk operands offered and changing throughout.
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b1);
    in_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      check_eq("bp_in_ready_run", 64'(in_ready), 64'd0);
      a = $urandom; b = $urandom; bin = ~bin;
    end while (!out_valid && cyc < 20);
    check_eq("bp_latency", 64'(cyc), 64'd4);
    repeat (6) begin
      check_eq("bp_in_ready_done", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
    end
    check_eq("bp_valid_held", 64'(out_valid), 64'd1);
    a = 32'h0000_0300; b = 32'h0000_0101; bin = 1'b0;
    sb.push_back(model(32'h0000_0300, 32'h0000_0101, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_idle_ready", 64'(in_ready),  64'd1);
    check_eq("bp_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("bp_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_result("bp_next");

    // Reset during the second RUN cycle.
    issue(32'd100, 32'd50, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    check_eq("abort_diff",     64'(diff),     64'd0);
    check_eq("abort_bout",     64'(bout),     64'd0);
    check_eq("abort_ovf",      64'(ovf),      64'd0);
    repeat (6) begin
      check_eq("abort_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    issue(32'd100, 32'd50, 1'b0, 1'b1);
    wait_result("after_abort");

    check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
